mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
Sequencer for the HI/LO register file. It accepts multiply, divide and move-to-HI/LO requests from the EX stage and runs an iterative signed/unsigned divider and a fixed-latency multiplier. It stalls the pipeline while busy and presents write-back to the HI/LO register as a wconfig/res_valid pair. Exception flush cancels any in-flight operation without writing HI/LO.

Parameters:
MUL_CYCLES, 3, cycles spent in MUL state (1..8)
DIV_ITERS, 32, restoring-division iterations (one quotient bit per cycle)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low (asserted when 0)
start  input  1  EX stage presents a valid op this cycle
op  input  4  0000 none, 0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU, 0101 MTHI, 0110 MTLO, 0111 MADD, 1000 MADDU, 1001 MSUB, 1010 MSUBU
src_a  input  32  rs operand / dividend
src_b  input  32  rt operand / divisor
hi_i  input  32  current HI (used only by accumulate ops)
lo_i  input  32  current LO (used only by accumulate ops)
flush  input  1  exception/flush, cancels in-flight op
stall_o  output  1  hold the pipeline
wconfig_o  output  2  [1] write HI, [0] write LO
res_valid_o  output  1  full 64-bit result valid (both halves)
hi_o  output  32  HI write data
lo_o  output  32  LO write data

Behaviour:
- States: IDLE, MUL, DIV, DONE. rst=0 -> IDLE; all outputs 0; counters and operand registers cleared.
- IDLE, start=1, flush=0:
  - MULT/MULTU (and MADD family when enabled): latch operands and sign flag -> MUL.
  - DIV/DIVU: latch magnitudes and sign flags -> DIV.
  - MTHI: next cycle wconfig_o=10, hi_o=src_a, res_valid_o=0; stays IDLE.
  - MTLO: next cycle wconfig_o=01, lo_o=src_a, res_valid_o=0; stays IDLE.
  - op none/reserved: no action.
- stall_o is combinational: 1 when (IDLE & start & op is multi-cycle & ~flush) | MUL | DIV; 0 otherwise, including DONE.
- MUL: counter runs for MUL_CYCLES cycles. 64-bit product is signed for MULT and unsigned for MULTU. Then -> DONE.
- DIV: restoring division on 32-bit magnitudes, DIV_ITERS cycles, then -> DONE.
  - Signed DIV: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - LO=quotient, HI=remainder.
  - Divisor 0: still runs full length; result HI=src_a, LO=32'hFFFFFFFF; no sign fixup.
- DONE: for one cycle, wconfig_o=11, res_valid_o=1, hi_o/lo_o=result; then -> IDLE. A new start is accepted only in IDLE, so back-to-back ops are separated by the DONE cycle.
- wconfig_o/res_valid_o are registered pulses, 1 cycle wide; 0 in all other cycles. hi_o/lo_o hold their last value when not writing.
- flush=1 in any state: -> IDLE next cycle, no write pulse, counters cleared. flush concurrent with start in IDLE: op ignored. flush in DONE cycle: the write pulse is suppressed (outputs forced 0 that cycle).
- rst=0 mid-operation: immediate return to reset values, no write.
- Latency from start cycle to write pulse: MUL_CYCLES+1 for multiply, DIV_ITERS+1 for divide, 1 for MTHI/MTLO. stall_o is high for the same number of cycles for multi-cycle ops.

Optional Feature:
MDU_MADD_EN:
- Defined: ops 0111-1010 are accepted. The product is computed as in MULT/MULTU (MADD/MSUB signed, MADDU/MSUBU unsigned). At entry to DONE, the result is {hi_i,lo_i} + product (MADD/MADDU) or {hi_i,lo_i} - product (MSUB/MSUBU), mod 2^64. hi_i/lo_i are sampled on the MUL->DONE transition.
- Undefined: ops 0111-1010 are treated as none; hi_i/lo_i are unused.

Test Plan:
- MULT src_a=FFFFFFFD (-3), src_b=5, MUL_CYCLES=3 -> stall_o high 4 cycles; then wconfig_o=11, res_valid_o=1, hi_o=FFFFFFFF, lo_o=FFFFFFF1.
- DIV src_a=FFFFFFF9 (-7), src_b=2 -> stall_o high 33 cycles; then lo_o=FFFFFFFD, hi_o=FFFFFFFF. DIVU 7/2 -> lo_o=3, hi_o=1.
- DIVU src_a=12345678, src_b=0 -> after 33 cycles hi_o=12345678, lo_o=FFFFFFFF, res_valid_o=1.
- MTHI src_a=DEADBEEF -> next cycle wconfig_o=10, res_valid_o=0, hi_o=DEADBEEF, stall_o never high. MTLO src_a=CAFEF00D -> next cycle wconfig_o=01, res_valid_o=0, lo_o=CAFEF00D, stall_o never high.
- DIV started, flush=1 at iteration 10 -> IDLE next cycle, stall_o=0, no write pulse. Same for rst=0 at iteration 10.
- With MDU_MADD_EN: hi_i=0, lo_i=10, MADDU 3*4 -> lo_o=22, hi_o=0. Same operands with MSUBU 5*4 -> {hi_o,lo_o}=FFFFFFFF_FFFFFFF6.

Source files
------------

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO sequencer driving a fixed-latency multiplier and a restoring divider.
// The optional MADD/MADDU/MSUB/MSUBU accumulate ops are enabled by defining MDU_MADD_EN.
module mdu_ctrl #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_ITERS  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        flush,
  output logic        stall_o,
  output logic [1:0]  wconfig_o,
  output logic        res_valid_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  localparam int CW = $clog2(((DIV_ITERS > MUL_CYCLES) ? DIV_ITERS : MUL_CYCLES) + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_ITERS - 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t r_state, w_nxt;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_a, r_b, r_quo, r_rem, r_hi, r_lo;
  logic [1:0]  r_acc, r_wcfg;
  logic        r_sgn, r_neg_q, r_neg_r, r_div0, r_valid;
  logic        w_is_mul, w_is_div, w_msgn, w_dsgn, w_multi, w_ge, w_kill;
  logic [1:0]  w_acc;
  logic [31:0] w_a_mag, w_b_mag, w_rem_nxt, w_quo_nxt, w_q, w_r;
  logic [32:0] w_shift;
  logic [63:0] w_pa, w_pb, w_prod, w_mul_res, w_div_res;
`ifdef MDU_MADD_EN
  assign w_is_mul = op inside {4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd10};
  assign w_msgn   = op inside {4'd1, 4'd7, 4'd9};
  assign w_acc    = {op inside {4'd9, 4'd10}, op inside {4'd7, 4'd8}};
`else
  assign w_is_mul = op inside {4'd1, 4'd2};
  assign w_msgn   = op == 4'd1;
  assign w_acc    = 2'b00;
`endif
  assign w_is_div = op inside {4'd3, 4'd4};
  assign w_dsgn   = op == 4'd3;
  assign w_multi  = w_is_mul | w_is_div;
  assign w_a_mag  = (w_dsgn & src_a[31]) ? -src_a : src_a;
  assign w_b_mag  = (w_dsgn & src_b[31]) ? -src_b : src_b;
  assign w_shift   = {r_rem, r_quo[31]};
  assign w_ge      = w_shift >= {1'b0, r_b};
  assign w_rem_nxt = w_ge ? 32'(w_shift - {1'b0, r_b}) : w_shift[31:0];
  assign w_quo_nxt = {r_quo[30:0], w_ge};
  assign w_q       = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_r       = r_neg_r ? -w_rem_nxt : w_rem_nxt;
  assign w_div_res = r_div0 ? {r_a, 32'hFFFF_FFFF} : {w_r, w_q};
  assign w_pa      = {{32{r_sgn & r_a[31]}}, r_a};
  assign w_pb      = {{32{r_sgn & r_b[31]}}, r_b};
  assign w_prod    = w_pa * w_pb;
  assign w_mul_res = r_acc[1] ? {hi_i, lo_i} - w_prod : r_acc[0] ? {hi_i, lo_i} + w_prod : w_prod;
  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_nxt;
  end
  // Next-state decode; flush always returns to IDLE
  always_comb begin
    w_nxt = flush ? IDLE :
            r_state == IDLE ? (start ? (w_is_mul ? MUL : w_is_div ? DIV : IDLE) : IDLE) :
            r_state == MUL  ? (r_cnt == MUL_LAST ? DONE : MUL) :
            r_state == DIV  ? (r_cnt == DIV_LAST ? DONE : DIV) : IDLE;
  end
  // Outputs: stall is combinational, write pulses are registered but masked by a flush in DONE
  always_comb begin
    stall_o     = (r_state == IDLE & start & w_multi & ~flush) | r_state == MUL | r_state == DIV;
    w_kill      = flush & r_state == DONE;
    wconfig_o   = w_kill ? 2'b00 : r_wcfg;
    res_valid_o = r_valid & ~w_kill;
    hi_o        = r_hi;
    lo_o        = r_lo;
  end
  // Operand capture, iteration counter, divider step and result/write-pulse registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_acc   <= '0;
      r_wcfg  <= '0;
      r_sgn   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_wcfg  <= 2'b00;
      r_valid <= 1'b0;
      if (flush) begin
        r_cnt <= '0;
      end else if (r_state == IDLE && start) begin
        if (w_multi) begin
          r_cnt   <= '0;
          r_a     <= src_a;
          r_b     <= w_is_div ? w_b_mag : src_b;
          r_quo   <= w_a_mag;
          r_rem   <= '0;
          r_sgn   <= w_msgn;
          r_acc   <= w_acc;
          r_neg_q <= w_dsgn & (src_a[31] ^ src_b[31]);
          r_neg_r <= w_dsgn & src_a[31];
          r_div0  <= src_b == '0;
        end
        if (op == 4'd5) begin
          r_wcfg <= 2'b10;
          r_hi   <= src_a;
        end
        if (op == 4'd6) begin
          r_wcfg <= 2'b01;
          r_lo   <= src_a;
        end
      end else if (r_state == MUL) begin
        r_cnt <= r_cnt == MUL_LAST ? '0 : r_cnt + CW'(1);
        if (r_cnt == MUL_LAST) begin
          {r_hi, r_lo} <= w_mul_res;
          r_wcfg       <= 2'b11;
          r_valid      <= 1'b1;
        end
      end else if (r_state == DIV) begin
        r_cnt <= r_cnt == DIV_LAST ? '0 : r_cnt + CW'(1);
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        if (r_cnt == DIV_LAST) begin
          {r_hi, r_lo} <= w_div_res;
          r_wcfg       <= 2'b11;
          r_valid      <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: vector table plus hand sequences for flush/reset corner cases of mdu_ctrl.
module tb_mdu_ctrl;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, flush = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] src_a = '0, src_b = '0, hi_i = '0, lo_i = '0;
  logic        stall_o, res_valid_o;
  logic [1:0]  wconfig_o;
  logic [31:0] hi_o, lo_o;
  int checks = 0, errors = 0;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, hi_i, lo_i;
    logic [1:0]  wcfg;
    logic        valid;
    logic [31:0] hi, lo;
    int          lat;
  } vec_t;
  vec_t vecs[$];
  vec_t exp_q[$];
  mdu_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hi_i(hi_i), .lo_i(lo_i), .flush(flush), .stall_o(stall_o), .wconfig_o(wconfig_o),
    .res_valid_o(res_valid_o), .hi_o(hi_o), .lo_o(lo_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] hin, input logic [31:0] lin, input logic [1:0] w,
                              input logic v, input logic [31:0] eh, input logic [31:0] el, input int l);
    vec_t t;
    t.op = o; t.a = a; t.b = b; t.hi_i = hin; t.lo_i = lin;
    t.wcfg = w; t.valid = v; t.hi = eh; t.lo = el; t.lat = l;
    return t;
  endfunction
  task automatic run(input vec_t v);
    vec_t e;
    int k, stalls;
    logic hit;
    exp_q.push_back(v);
    @(negedge clk);
    start = 1'b1; op = v.op; src_a = v.a; src_b = v.b; hi_i = v.hi_i; lo_i = v.lo_i;
    stalls = 0; hit = 1'b0; k = 0;
    while (!hit && k <= 60) begin
      #1;
      if (wconfig_o != 2'b00 || res_valid_o) hit = 1'b1;
      else begin
        if (stall_o) stalls++;
        k++;
        @(negedge clk);
        start = 1'b0; op = '0;
      end
    end
    start = 1'b0; op = '0;
    e = exp_q.pop_front();
    if (!hit) begin
      checks++; errors++;
      $display("FAIL timeout op %0d: no write pulse within 60 cycles", e.op);
    end else begin
      chk($sformatf("op%0d latency", e.op), 64'(k), 64'(e.lat));
      chk($sformatf("op%0d stall cycles", e.op), 64'(stalls), 64'(e.wcfg == 2'b11 ? e.lat : 0));
      chk($sformatf("op%0d stall at pulse", e.op), 64'(stall_o), 64'(0));
      chk($sformatf("op%0d wconfig", e.op), 64'(wconfig_o), 64'(e.wcfg));
      chk($sformatf("op%0d res_valid", e.op), 64'(res_valid_o), 64'(e.valid));
      if (e.wcfg[1]) chk($sformatf("op%0d hi", e.op), 64'(hi_o), 64'(e.hi));
      if (e.wcfg[0]) chk($sformatf("op%0d lo", e.op), 64'(lo_o), 64'(e.lo));
      @(negedge clk); #1;
      chk($sformatf("op%0d pulse width", e.op), {61'd0, wconfig_o, res_valid_o}, 64'(0));
      if (e.wcfg[1]) chk($sformatf("op%0d hi hold", e.op), 64'(hi_o), 64'(e.hi));
    end
  endtask
  task automatic watch(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      if (wconfig_o != 2'b00 || res_valid_o) pulses++;
    end
  endtask
  task automatic start_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
  endtask
  initial begin
    int p;
    vecs.push_back(mk(4'd1, 32'hFFFF_FFFD, 32'd5, 0, 0, 2'b11, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 4));
    vecs.push_back(mk(4'd2, 32'hFFFF_FFFD, 32'd5, 0, 0, 2'b11, 1'b1, 32'h0000_0004, 32'hFFFF_FFF1, 4));
    vecs.push_back(mk(4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0, 2'b11, 1'b1, 32'h3FFF_FFFF, 32'h0000_0001, 4));
    vecs.push_back(mk(4'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, 2'b11, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33));
    vecs.push_back(mk(4'd4, 32'd7, 32'd2, 0, 0, 2'b11, 1'b1, 32'd1, 32'd3, 33));
    vecs.push_back(mk(4'd4, 32'h1234_5678, 32'd0, 0, 0, 2'b11, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 33));
    vecs.push_back(mk(4'd3, 32'd7, 32'hFFFF_FFFE, 0, 0, 2'b11, 1'b1, 32'd1, 32'hFFFF_FFFD, 33));
    vecs.push_back(mk(4'd4, 32'hFFFF_FFFF, 32'd1, 0, 0, 2'b11, 1'b1, 32'd0, 32'hFFFF_FFFF, 33));
    vecs.push_back(mk(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 2'b11, 1'b1, 32'd0, 32'h8000_0000, 33));
    vecs.push_back(mk(4'd3, 32'hFFFF_FFF9, 32'd0, 0, 0, 2'b11, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 33));
    vecs.push_back(mk(4'd5, 32'hDEAD_BEEF, 32'd0, 0, 0, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'd0, 1));
    vecs.push_back(mk(4'd6, 32'hCAFE_F00D, 32'd0, 0, 0, 2'b01, 1'b0, 32'd0, 32'hCAFE_F00D, 1));
`ifdef MDU_MADD_EN
    vecs.push_back(mk(4'd8, 32'd3, 32'd4, 32'd0, 32'd10, 2'b11, 1'b1, 32'd0, 32'd22, 4));
    vecs.push_back(mk(4'd10, 32'd5, 32'd4, 32'd0, 32'd10, 2'b11, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF6, 4));
    vecs.push_back(mk(4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 2'b11, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4));
    vecs.push_back(mk(4'd9, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd1, 2'b11, 1'b1, 32'd0, 32'd3, 4));
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("reset outputs", {stall_o, wconfig_o, res_valid_o, hi_o, lo_o}, 64'(0));
    rst = 1'b1;
    for (int i = 0; i < vecs.size(); i++) run(vecs[i]);
`ifndef MDU_MADD_EN
    start_op(4'd7, 32'd3, 32'd4);
    #1;
    chk("madd disabled stall", 64'(stall_o), 64'(0));
    @(negedge clk); start = 1'b0; op = '0;
    watch(6, p);
    chk("madd disabled no pulse", 64'(p), 64'(0));
`endif
    start_op(4'd4, 32'd100, 32'd7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); start = 1'b0; op = '0;
    end
    flush = 1'b1;
    #1;
    chk("flush div stall before", 64'(stall_o), 64'(1));
    @(negedge clk); flush = 1'b0;
    #1;
    chk("flush div stall after", 64'(stall_o), 64'(0));
    watch(40, p);
    chk("flush div no pulse", 64'(p), 64'(0));
    start_op(4'd4, 32'd100, 32'd7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); start = 1'b0; op = '0;
    end
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    chk("reset mid div outputs", {stall_o, wconfig_o, res_valid_o, hi_o, lo_o}, 64'(0));
    watch(40, p);
    chk("reset mid div no pulse", 64'(p), 64'(0));
    start_op(4'd1, 32'd3, 32'd3);
    flush = 1'b1;
    #1;
    chk("flush with start stall", 64'(stall_o), 64'(0));
    @(negedge clk); start = 1'b0; op = '0; flush = 1'b0;
    watch(8, p);
    chk("flush with start no pulse", 64'(p), 64'(0));
    start_op(4'd2, 32'd6, 32'd7);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); start = 1'b0; op = '0;
    end
    flush = 1'b1;
    #1;
    chk("flush in done wconfig", 64'(wconfig_o), 64'(0));
    chk("flush in done res_valid", 64'(res_valid_o), 64'(0));
    @(negedge clk); flush = 1'b0;
    watch(6, p);
    chk("flush in done no late pulse", 64'(p), 64'(0));
    run(mk(4'd2, 32'd6, 32'd7, 0, 0, 2'b11, 1'b1, 32'd0, 32'd42, 4));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
